// File: rtl/clock_gate_pkg.sv
// Shared defaults for the clock-gated register: data width, activity counter width
// and the counter saturation value for the default counter width.
package clock_gate_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned CNT_MAX   = (1 << DEF_CNT_W) - 1;

endpackage

// File: rtl/clock_gate_reg_if.sv
// Signal bundle of the clock-gated register. The master drives en/d (and test_en
// when CLOCK_GATE_TEST_EN is defined); the slave returns q, gclk and act_cnt.
interface clock_gate_reg_if
  import clock_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  // No handshake: en is a level that qualifies clk edges. d is captured on each
  // passed edge, and q and act_cnt change only on those edges.
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             gclk;
  logic [CNT_W-1:0] act_cnt;
`ifdef CLOCK_GATE_TEST_EN
  logic             test_en;

  modport master (output en, output d, output test_en,
                  input q, input gclk, input act_cnt);
  modport slave  (input en, input d, input test_en,
                  output q, output gclk, output act_cnt);
`else
  modport master (output en, output d,
                  input q, input gclk, input act_cnt);
  modport slave  (input en, input d,
                  output q, output gclk, output act_cnt);
`endif

endinterface

// File: rtl/clock_gate_reg_icg_cell.sv
// Latch-based integrated clock gate. The enable is captured while clk is low and
// held while clk is high, so the gated pulse can never be cut short or glitch.
module icg_cell (
  input  logic clk,
  input  logic rst,
  input  logic en_in,
  output logic gclk
);

  logic r_en_lat;

  always_latch begin
    if (rst)
      r_en_lat <= 1'b0;
    else if (!clk)
      r_en_lat <= en_in;
  end

  assign gclk = clk & r_en_lat;

endmodule

// File: rtl/clock_gate_reg.sv
// Data register and saturating activity counter clocked by a latch-gated clock.
// Optional macro CLOCK_GATE_TEST_EN adds a test_en override that forces the gate open.
module clock_gate_reg
  import clock_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  clock_gate_reg_if.slave  bus
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

  logic             w_en_in;
  logic             w_gclk;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_act_cnt;

`ifdef CLOCK_GATE_TEST_EN
  assign w_en_in = bus.en | bus.test_en;
`else
  assign w_en_in = bus.en;
`endif

  icg_cell u_icg (
    .clk   (clk),
    .rst   (rst),
    .en_in (w_en_in),
    .gclk  (w_gclk)
  );

  // Counter holds at all-ones rather than wrapping.
  always_ff @(posedge w_gclk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_act_cnt <= '0;
    end else begin
      r_q <= bus.d;
      if (r_act_cnt != LP_CNT_MAX)
        r_act_cnt <= r_act_cnt + 1'b1;
    end
  end

  assign bus.q       = r_q;
  assign bus.gclk    = w_gclk;
  assign bus.act_cnt = r_act_cnt;

endmodule

// File: tb/tb_clock_gate_reg.sv
// Directed bench for clock_gate_reg: reset, gating latency, glitch immunity,
// a table of enable/data steps, counter saturation and mid-cycle reset.
module tb_clock_gate_reg;
  import clock_gate_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_edges;
  int   edges0;

  clock_gate_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  clock_gate_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset: posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial n_edges = 0;
  always @(posedge bus.gclk) n_edges = n_edges + 1;

  typedef struct {
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_q;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_gclk;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] eq,
                            input logic [CNT_W-1:0] ec, input logic eg);
    check({tag, ".q"},    32'(bus.q),       32'(eq));
    check({tag, ".cnt"},  32'(bus.act_cnt), 32'(ec));
    check({tag, ".gclk"}, 32'(bus.gclk),    32'(eg));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{1'b1, 4'hA, 4'hA, 8'd3, 1'b1};
    vecs[1] = '{1'b1, 4'h5, 4'h5, 8'd4, 1'b1};
    vecs[2] = '{1'b0, 4'hF, 4'h5, 8'd4, 1'b0};
    vecs[3] = '{1'b1, 4'hF, 4'hF, 8'd5, 1'b1};
    vecs[4] = '{1'b0, 4'h0, 4'hF, 8'd5, 1'b0};
    vecs[5] = '{1'b0, 4'h3, 4'hF, 8'd5, 1'b0};
    vecs[6] = '{1'b1, 4'h3, 4'h3, 8'd6, 1'b1};
    vecs[7] = '{1'b1, 4'h0, 4'h0, 8'd7, 1'b1};

    rst    = 1'b1;
    bus.en = 1'b1;
    bus.d  = 4'h0;
`ifdef CLOCK_GATE_TEST_EN
    bus.test_en = 1'b0;
`endif
    // reset held with en=1 and d toggling
    #7;  check_outs("rst_t7", 4'h0, 8'd0, 1'b0);  bus.d = 4'h1;
    #10; check_outs("rst_t17", 4'h0, 8'd0, 1'b0); bus.d = 4'h2;
    #3;  rst = 1'b0; bus.en = 1'b1; bus.d = 4'h1;
    // t=27: first edge after reset passed
    #7;  check_outs("first_edge", 4'h1, 8'd1, 1'b1);
    bus.en = 1'b0; bus.d = 4'h0;
    #2;  check("pulse_intact.gclk", 32'(bus.gclk), 32'd1);
    // t=37: posedge 35 suppressed
    #8;  check_outs("suppressed", 4'h1, 8'd1, 1'b0);
    bus.en = 1'b1;
    // t=47: en raised while clk high passes at 45
    #10; check_outs("en_late", 4'h0, 8'd2, 1'b1);
    bus.en = 1'b0;
    edges0 = n_edges;
    #100;
    check("idle.edges", 32'(n_edges - edges0), 32'd0);
    check_outs("idle", 4'h0, 8'd2, 1'b0);

    // t=147 onward: one vector per clock, applied 2 ns after posedge
    for (int i = 0; i < 8; i++) begin
      bus.en = vecs[i].en;
      bus.d  = vecs[i].d;
      #10;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_gclk);
    end

    // t=227: en pulses inside the low phase, last value (0) wins
    bus.en = 1'b0;
    #4; bus.en = 1'b1;
    #2; bus.en = 1'b0;
    #4; check_outs("lowglitch_off", 4'h0, 8'd7, 1'b0);
    #4; bus.en = 1'b0;
    #2; bus.en = 1'b1;
    #4; check_outs("lowglitch_on", 4'h0, 8'd8, 1'b1);
    // t=247: en toggles inside the high phase, pulse stays whole
    bus.en = 1'b0;
    #1; bus.en = 1'b1;
    #1; bus.en = 1'b0;
    check("highglitch.gclk", 32'(bus.gclk), 32'd1);
    #8; check_outs("highglitch_next", 4'h0, 8'd8, 1'b0);

    // t=257: saturation after 260 enabled cycles
    bus.en = 1'b1; bus.d = 4'h9;
    repeat (260) #10;
    check_outs("saturate", 4'h9, 8'd255, 1'b1);
    check("saturate.max", 32'(bus.act_cnt), 32'(CNT_MAX));

    // reset pulse in the middle of a high phase
    rst = 1'b1;
    #1;  check_outs("midrst", 4'h0, 8'd0, 1'b0);
    #10; check_outs("midrst_hold", 4'h0, 8'd0, 1'b0);
    rst = 1'b0;
    #9;  check_outs("rst_release", 4'h9, 8'd1, 1'b1);

`ifdef CLOCK_GATE_TEST_EN
    bus.en = 1'b0; bus.test_en = 1'b1; bus.d = 4'h6;
    #10; check_outs("test_en", 4'h6, 8'd2, 1'b1);
    bus.test_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
